// File: rtl/mm2s_pack_if.sv
// Stream bundle for mm2s_pack: systolic-array result beats in, AXI-Stream out.
//   in_data/in_valid/in_ready : wide result beat (N1 words of D_W_ACC bits), word i at [i*D_W_ACC +: D_W_ACC]
//   m_axis_*                  : packed output lanes (LANES words of OUT_W bits), lane 0 in lowest bits
// slave  : view of the packer itself
// master : view of the environment that feeds results and sinks the stream
interface mm2s_pack_if #(
  parameter int unsigned D_W_ACC = 32,
  parameter int unsigned N1      = 4,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned LANES   = 1
);
  logic [N1*D_W_ACC-1:0]    in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*OUT_W-1:0]   m_axis_tdata;
  logic [LANES*OUT_W/8-1:0] m_axis_tkeep;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;

  modport slave (
    input  in_data, in_valid, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output in_data, in_valid, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/mm2s_pack.sv
// Buffers wide accumulator beats in a FIFO and serialises them into an AXI-Stream
// of LANES words per beat, converting each word to OUT_W bits (truncate or saturate).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle frame start (honoured only when idle)
//   num_words, sat_mode  : frame length in output words and conversion mode, latched on start
//   bus                  : input beats and AXI-Stream output (mm2s_pack_if.slave)
//   busy                 : high while the frame is running
//   done                 : one-cycle pulse when the frame finishes
//   overflow             : sticky, an input beat was dropped because the FIFO was full
module mm2s_pack #(
  parameter int unsigned D_W_ACC    = 32,
  parameter int unsigned N1         = 4,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned LANES      = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             sat_mode,
  mm2s_pack_if.slave       bus,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int unsigned BEATS  = N1 / LANES;
  localparam int unsigned BI_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned IN_W   = N1 * D_W_ACC;
  localparam int unsigned KEEP_B = OUT_W / 8;
  // Signed clamp limits expressed at accumulator width
  localparam logic [D_W_ACC-1:0] SAT_MAX = {{(D_W_ACC-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [D_W_ACC-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [IN_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr, rd_ptr;
  logic [BI_W-1:0]        beat_idx;
  logic [CNT_W-1:0]       num_q, emitted;
  logic                   sat_q;
  logic                   fifo_empty, fifo_full, push, hs, load, ld_last;
  logic [CNT_W:0]         base;
  logic [IN_W-1:0]        entry;
  logic [LANES*OUT_W-1:0] ld_data;
  logic [LANES*KEEP_B-1:0] ld_keep;

  // Convert one accumulator word to an output lane word
  function automatic logic [OUT_W-1:0] conv(input logic [D_W_ACC-1:0] w, input logic sat);
    logic [OUT_W-1:0] r;
    r = w[OUT_W-1:0];
    if (sat) begin
      if ($signed(w) > $signed(SAT_MAX))      r = SAT_MAX[OUT_W-1:0];
      else if ($signed(w) < $signed(SAT_MIN)) r = SAT_MIN[OUT_W-1:0];
    end
    return r;
  endfunction

  // Extra pointer bit distinguishes full from empty
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign entry      = mem[rd_ptr[PTR_W-1:0]];
  assign push       = bus.in_valid & bus.in_ready;
  assign hs         = bus.m_axis_tvalid & bus.m_axis_tready;
  // Refill the output register when it is empty or draining, never past the final beat
  assign load       = (state == RUN) && !fifo_empty &&
                      (!bus.m_axis_tvalid || bus.m_axis_tready) &&
                      !(hs && bus.m_axis_tlast);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (num_words != '0)) state_nxt = RUN;
      RUN:     if (hs && bus.m_axis_tlast)     state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy         = 1'b0;
    bus.in_ready = 1'b0;
    if (state == RUN) begin
      busy         = 1'b1;
      bus.in_ready = !fifo_full;
    end
  end

  // Next output beat; base is the word index it starts at once any current handshake retires
  always_comb begin
    base    = {1'b0, emitted} + (hs ? (CNT_W+1)'(LANES) : (CNT_W+1)'(0));
    ld_last = (base + (CNT_W+1)'(LANES)) >= {1'b0, num_q};
    ld_data = '0;
    ld_keep = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if ((base + (CNT_W+1)'(j)) < {1'b0, num_q}) begin
        ld_data[j*OUT_W +: OUT_W] =
          conv(entry[(32'(beat_idx)*LANES + j)*D_W_ACC +: D_W_ACC], sat_q);
        ld_keep[j*KEEP_B +: KEEP_B] = '1;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= bus.in_data;
  end

  // Frame control, FIFO pointers and registered stream output
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      beat_idx          <= '0;
      num_q             <= '0;
      emitted           <= '0;
      sat_q             <= 1'b0;
      done              <= 1'b0;
      overflow          <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tdata  <= '0;
    end else begin
      done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (state == IDLE && start) begin
        num_q    <= num_words;
        sat_q    <= sat_mode;
        emitted  <= '0;
        overflow <= 1'b0;
        beat_idx <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        done     <= (num_words == '0);
      end
      if (state == RUN && bus.in_valid && !bus.in_ready) overflow <= 1'b1;
      if (hs) begin
        bus.m_axis_tvalid <= 1'b0;
        emitted <= bus.m_axis_tlast ? num_q : emitted + CNT_W'(LANES);
        if (bus.m_axis_tlast) begin
          done             <= 1'b1;
          bus.m_axis_tlast <= 1'b0;
          bus.m_axis_tkeep <= '0;
          bus.m_axis_tdata <= '0;
        end
      end
      if (load) begin
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tdata  <= ld_data;
        bus.m_axis_tkeep  <= ld_keep;
        bus.m_axis_tlast  <= ld_last;
        if (beat_idx == BI_W'(BEATS-1)) begin
          beat_idx <= '0;
          rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
        end else begin
          beat_idx <= beat_idx + BI_W'(1);
        end
      end
      // Drop whatever the frame did not consume
      if (state == FLUSH) begin
        rd_ptr   <= wr_ptr;
        beat_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mm2s_pack.sv
// Bench for mm2s_pack (D_W_ACC=32, N1=4, OUT_W=16, LANES=2, FIFO_DEPTH=2): directed
// frames with literal expectations plus randomized frames checked against a word-list model.
module tb_mm2s_pack;
  localparam int unsigned DW = 32, N1 = 4, OW = 16, LN = 2, FD = 2, CW = 16;
  localparam int unsigned KB = OW / 8;

  logic          clk = 1'b0;
  logic          rst, start, sat_mode, busy, done, overflow;
  logic [CW-1:0] num_words;

  mm2s_pack_if #(.D_W_ACC(DW), .N1(N1), .OUT_W(OW), .LANES(LN)) bus ();

  mm2s_pack #(.D_W_ACC(DW), .N1(N1), .OUT_W(OW), .LANES(LN), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .sat_mode(sat_mode),
    .bus(bus), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Word conversion straight from the numeric rule
  function automatic logic [OW-1:0] conv(input logic [DW-1:0] w, input logic s);
    longint v, hi, lo;
    v  = longint'($signed(w));
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -hi - 1;
    if (s) begin
      if (v > hi)      v = hi;
      else if (v < lo) v = lo;
    end
    return OW'(v);
  endfunction

  function automatic logic [N1*DW-1:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Model: expected word list of the frame, index of next word on the stream, frame phase
  typedef enum {M_IDLE, M_RUN, M_FLUSH} mph_t;
  mph_t            ph = M_IDLE;
  logic [OW-1:0]   ew[$];
  int unsigned     m_n = 0, m_emit = 0;
  logic            m_sat = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  bit              chk_zero = 1'b0, prev_stall = 1'b0, saw_done = 1'b0, cap_en = 1'b0;
  logic [LN*OW-1:0] prev_data;
  logic [LN*KB-1:0] prev_keep;
  logic            prev_last;
  int              cyc = 0;
  logic [LN*OW-1:0] cap_d[$];
  logic [LN*KB-1:0] cap_k[$];
  logic            cap_l[$];
  int              cap_c[$];

  // Compare outputs with the model mid-cycle, then advance the model over the coming edge
  always @(negedge clk) begin
    cyc++;
    if (chk_zero) begin
      chk("rst_tvalid", bus.m_axis_tvalid, 0);
      chk("rst_tlast", bus.m_axis_tlast, 0);
      chk("rst_tkeep", bus.m_axis_tkeep, 0);
      chk("rst_tdata", bus.m_axis_tdata, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      chk_zero = 1'b0;
    end
    chk("busy", busy, ph == M_RUN);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    if (ph != M_RUN) begin
      chk("in_ready_not_run", bus.in_ready, 0);
      chk("tvalid_not_run", bus.m_axis_tvalid, 0);
    end
    if (prev_stall) begin
      chk("stall_tvalid", bus.m_axis_tvalid, 1);
      chk("stall_tdata", bus.m_axis_tdata, prev_data);
      chk("stall_tkeep", bus.m_axis_tkeep, prev_keep);
      chk("stall_tlast", bus.m_axis_tlast, prev_last);
    end
    if (bus.m_axis_tvalid) begin
      for (int j = 0; j < LN; j++) begin
        if (m_emit + j < m_n) begin
          if (m_emit + j < ew.size())
            chk("lane_data", bus.m_axis_tdata[j*OW +: OW], ew[m_emit + j]);
          else begin
            n_cmp++; n_bad++;
            $display("FAIL lane_underrun: word %0d shown, only %0d words accepted", m_emit + j, ew.size());
          end
          chk("lane_keep", bus.m_axis_tkeep[j*KB +: KB], (1 << KB) - 1);
        end else begin
          chk("pad_data", bus.m_axis_tdata[j*OW +: OW], 0);
          chk("pad_keep", bus.m_axis_tkeep[j*KB +: KB], 0);
        end
      end
      chk("tlast", bus.m_axis_tlast, (m_emit + LN) >= m_n);
    end
    prev_stall = bus.m_axis_tvalid & !bus.m_axis_tready;
    prev_data  = bus.m_axis_tdata;
    prev_keep  = bus.m_axis_tkeep;
    prev_last  = bus.m_axis_tlast;
    if (done) saw_done = 1'b1;
    if (cap_en && bus.m_axis_tvalid && bus.m_axis_tready) begin
      cap_d.push_back(bus.m_axis_tdata);
      cap_k.push_back(bus.m_axis_tkeep);
      cap_l.push_back(bus.m_axis_tlast);
      cap_c.push_back(cyc);
    end
    m_done = 1'b0;
    if (rst) begin
      ph = M_IDLE; ew.delete(); m_ovf = 1'b0; m_emit = 0; m_n = 0;
      chk_zero = 1'b1; prev_stall = 1'b0;
    end else begin
      case (ph)
        M_IDLE: if (start) begin
          m_n = num_words; m_sat = sat_mode; m_ovf = 1'b0; m_emit = 0; ew.delete();
          if (m_n == 0) m_done = 1'b1; else ph = M_RUN;
        end
        M_RUN: begin
          if (bus.in_valid) begin
            if (bus.in_ready) begin
              for (int i = 0; i < N1; i++)
                if (ew.size() < m_n) ew.push_back(conv(bus.in_data[i*DW +: DW], m_sat));
            end else m_ovf = 1'b1;
          end
          if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (m_emit + LN >= m_n) begin ph = M_FLUSH; m_done = 1'b1; end
            m_emit += LN;
          end
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int unsigned n, input logic s);
    saw_done = 1'b0;
    num_words = CW'(n); sat_mode = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [N1*DW-1:0] d);
    int k = 0;
    bus.in_data = d; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= 200) begin n_bad++; $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", k); end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!saw_done && k < 1000) begin tick(); k++; end
    n_cmp++;
    if (!saw_done) begin n_bad++; $display("FAIL %s_done_timeout: done 0 after %0d cycles, required 1", tag, k); end
  endtask

  task automatic cap_clear();
    cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_c.delete();
  endtask

  function automatic logic [N1*DW-1:0] rand_beat();
    logic [N1*DW-1:0] b;
    for (int i = 0; i < N1; i++)
      b[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? DW'($urandom()) : DW'($urandom_range(0, 65535)) - DW'(32768);
    return b;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, required summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy [3];
    rst = 1'b1; start = 1'b0; num_words = '0; sat_mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.m_axis_tready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Two lanes, five words: (1,2),(3,4),(5,pad) back to back, words 6..8 discarded
    bus.m_axis_tready = 1'b1; cap_clear(); cap_en = 1'b1;
    do_start(5, 1'b0);
    send_beat(pack4(1, 2, 3, 4));
    send_beat(pack4(5, 6, 7, 8));
    wait_done("lanes");
    cap_en = 1'b0;
    chk("lanes_nbeats", cap_d.size(), 3);
    if (cap_d.size() == 3) begin
      chk("lanes_b0", cap_d[0], 32'h0002_0001);
      chk("lanes_b1", cap_d[1], 32'h0004_0003);
      chk("lanes_b2", cap_d[2], 32'h0000_0005);
      chk("lanes_k1", cap_k[1], 4'hF);
      chk("lanes_k2", cap_k[2], 4'h3);
      chk("lanes_l1", cap_l[1], 0);
      chk("lanes_l2", cap_l[2], 1);
      chk("lanes_rate", cap_c[2] - cap_c[0], 2);
    end

    // Saturate then truncate the same words
    for (int m = 1; m >= 0; m--) begin
      cap_clear(); cap_en = 1'b1;
      do_start(4, m[0]);
      send_beat(pack4(40000, 32'hFFFF_63C0, 5, 32'hFFFF_FFFB));
      wait_done("conv");
      cap_en = 1'b0;
      chk("conv_nbeats", cap_d.size(), 2);
      if (cap_d.size() == 2) begin
        chk("conv_b0", cap_d[0], (m == 1) ? 32'h8000_7FFF : 32'h63C0_9C40);
        chk("conv_b1", cap_d[1], 32'hFFFB_0005);
      end
    end

    // Overflow with a stalled sink: third consecutive beat is refused
    bus.m_axis_tready = 1'b0;
    do_start(8, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = pack4(4*i+1, 4*i+2, 4*i+3, 4*i+4);
      @(negedge clk);
      rdy[i] = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("ovf_rdy0", rdy[0], 1);
    chk("ovf_rdy1", rdy[1], 1);
    chk("ovf_rdy2", rdy[2], 0);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    tick();
    bus.m_axis_tready = 1'b1;
    wait_done("ovf");
    do_start(4, 1'b0);
    @(negedge clk);
    chk("ovf_cleared", overflow, 0);
    tick();
    send_beat(pack4(9, 10, 11, 12));
    wait_done("ovf_next");

    // Reset mid-frame, then a normal frame and an empty frame
    do_start(8, 1'b0);
    send_beat(pack4(1, 2, 3, 4));
    send_beat(pack4(5, 6, 7, 8));
    for (int k = 0; k < 50 && m_emit < 2; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    tick();
    do_start(4, 1'b0);
    send_beat(pack4(21, 22, 23, 24));
    wait_done("after_rst");
    do_start(0, 1'b0);
    wait_done("zero");

    // Randomized frames: random sink patterns including strict 1010 toggling
    for (int f = 0; f < 40; f++) begin
      int unsigned n;
      int mode, k;
      n = $urandom_range(0, 20);
      mode = $urandom_range(0, 2);
      do_start(n, 1'($urandom_range(0, 1)));
      bus.m_axis_tready = 1'b1;
      k = 0;
      while (!saw_done && k < 1000) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = rand_beat();
        start        = (k > 0 && n != 0 && $urandom_range(0, 15) == 0);
        case (mode)
          0:       bus.m_axis_tready = 1'($urandom_range(0, 1));
          1:       bus.m_axis_tready = ~bus.m_axis_tready;
          default: bus.m_axis_tready = 1'b1;
        endcase
        tick();
        k++;
      end
      start = 1'b0;
      n_cmp++;
      if (!saw_done) begin n_bad++; $display("FAIL rand_done_timeout: frame %0d done 0, required 1", f); end
      bus.in_valid = 1'b1;
      bus.in_data  = rand_beat();
      repeat (2) tick();
      bus.in_valid = 1'b0;
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
